// File: rtl/counter_pkg.sv
// counter_pkg: shared constants and types for the counter block.
//   DEFAULT_BITS : default counter width (8).
//   dir_e        : counting direction, DIR_UP = 0, DIR_DOWN = 1.
package counter_pkg;

    localparam int DEFAULT_BITS = 8;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/counter_next.sv
// counter_next: combinational next-step value and boundary flag for the counter.
//   count_i : current count
//   dir_i   : step direction
//   next_o  : value after one step (modulo, or held at the boundary when SATURATE)
//   wrap_o  : step starts at the boundary for its direction (max going up, 0 going down)
module counter_next
    import counter_pkg::*;
#(
    parameter int BITS     = DEFAULT_BITS,
    parameter bit SATURATE = 1'b0
) (
    input  logic [BITS-1:0] count_i,
    input  dir_e            dir_i,
    output logic [BITS-1:0] next_o,
    output logic            wrap_o
);

    localparam logic [BITS-1:0] ONE = BITS'(1);

    logic            at_bound;
    logic [BITS-1:0] stepped;

    always_comb begin
        at_bound = (dir_i == DIR_UP) ? (&count_i) : ~(|count_i);
        stepped  = (dir_i == DIR_UP) ? count_i + ONE : count_i - ONE;
        // In saturating mode a step at the boundary is blocked; the flag still fires.
        next_o   = (SATURATE && at_bound) ? count_i : stepped;
        wrap_o   = at_bound;
    end

endmodule

// File: rtl/counter.sv
// counter: loadable up/down counter with a registered boundary-crossing pulse.
//   clk            : clock, all state on rising edge
//   reset          : synchronous active-low reset
//   enable         : step the count when high
//   inverseCounter : 0 = count up, 1 = count down
//   load           : load data into count (wins over enable)
//   data           : load value
//   count          : registered count
//   wrap           : registered one-cycle pulse after a boundary step
// Build option: define COUNTER_SATURATE_EN to hold at the boundaries instead of wrapping.
module counter
    import counter_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            inverseCounter,
    input  logic            load,
    input  logic [BITS-1:0] data,
    output logic [BITS-1:0] count,
    output logic            wrap
);

`ifdef COUNTER_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [BITS-1:0] count_d, count_q, step_val;
    logic            wrap_d, wrap_q, step_wrap;

    counter_next #(
        .BITS     (BITS),
        .SATURATE (SATURATE)
    ) u_next (
        .count_i (count_q),
        .dir_i   (dir_e'(inverseCounter)),
        .next_o  (step_val),
        .wrap_o  (step_wrap)
    );

    always_comb begin
        count_d = load ? data : (enable ? step_val : count_q);
        // Loading never reports a boundary crossing, whatever the value.
        wrap_d  = !load && enable && step_wrap;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_counter.sv
// tb_counter: directed vector bench for counter (BITS = 8).
module tb_counter;

`ifdef COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        string      name;
        logic       rst_n;
        logic       en;
        logic       inv;
        logic       ld;
        logic [7:0] d;
        logic [7:0] exp_c;
        logic       exp_w;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       inverseCounter = 1'b0;
    logic       load = 1'b0;
    logic [7:0] data = '0;
    logic [7:0] count;
    logic       wrap;

    int n_vec = 0;
    int n_err = 0;

    vec_t tbl[$];

    counter #(.BITS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .inverseCounter (inverseCounter),
        .load           (load),
        .data           (data),
        .count          (count),
        .wrap           (wrap)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(string name, logic r, logic e, logic i, logic l,
                               logic [7:0] d, logic [7:0] c, logic w);
        vec_t x;
        x.name = name; x.rst_n = r; x.en = e; x.inv = i; x.ld = l;
        x.d = d; x.exp_c = c; x.exp_w = w;
        return x;
    endfunction

    task automatic check(string name, logic [7:0] c, logic w);
        n_vec++;
        if (count !== c || wrap !== w) begin
            n_err++;
            $display("FAIL %s: count=%0d wrap=%0b, required count=%0d wrap=%0b",
                     name, count, wrap, c, w);
        end
    endtask

    task automatic apply(vec_t x);
        @(negedge clk);
        reset = x.rst_n; enable = x.en; inverseCounter = x.inv; load = x.ld; data = x.d;
        @(posedge clk);
        #1;
        check(x.name, x.exp_c, x.exp_w);
    endtask

    initial begin
        // reset then count up
        tbl.push_back(v("rst_state", 0, 1, 0, 0,   0,   0, 0));
        tbl.push_back(v("rst_up1",   1, 1, 0, 0,   0,   1, 0));
        tbl.push_back(v("rst_up2",   1, 1, 0, 0,   0,   2, 0));
        tbl.push_back(v("rst_up3",   1, 1, 0, 0,   0,   3, 0));
        // load 55, up 4, down 4
        tbl.push_back(v("ld55",      1, 1, 0, 1,  55,  55, 0));
        tbl.push_back(v("up56",      1, 1, 0, 0,   0,  56, 0));
        tbl.push_back(v("up57",      1, 1, 0, 0,   0,  57, 0));
        tbl.push_back(v("up58",      1, 1, 0, 0,   0,  58, 0));
        tbl.push_back(v("up59",      1, 1, 0, 0,   0,  59, 0));
        tbl.push_back(v("dn58",      1, 1, 1, 0,   0,  58, 0));
        tbl.push_back(v("dn57",      1, 1, 1, 0,   0,  57, 0));
        tbl.push_back(v("dn56",      1, 1, 1, 0,   0,  56, 0));
        tbl.push_back(v("dn55",      1, 1, 1, 0,   0,  55, 0));
        // held load, then down through zero
        tbl.push_back(v("hold_ld_a", 1, 1, 1, 1,   1,   1, 0));
        tbl.push_back(v("hold_ld_b", 1, 1, 1, 1,   1,   1, 0));
        tbl.push_back(v("hold_ld_c", 1, 1, 1, 1,   1,   1, 0));
        tbl.push_back(v("dn_to0",    1, 1, 1, 0,   0,   0, 0));
        tbl.push_back(v("dn_wrap",   1, 1, 1, 0,   0, SAT ? 8'd0 : 8'd255, 1));
        tbl.push_back(v("dn_pulse1", 1, 0, 1, 0,   0, SAT ? 8'd0 : 8'd255, 0));
        // load 254, up through max
        tbl.push_back(v("ld254",     1, 1, 0, 1, 254, 254, 0));
        tbl.push_back(v("up255",     1, 1, 0, 0,   0, 255, 0));
        tbl.push_back(v("up_wrap",   1, 1, 0, 0,   0, SAT ? 8'd255 : 8'd0, 1));
        tbl.push_back(v("up_after",  1, 1, 0, 0,   0, SAT ? 8'd255 : 8'd1, SAT));
        // hold and load with enable low
        tbl.push_back(v("ld10",      1, 0, 0, 1,  10,  10, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v("hold10",  1, 0, i[0], 0, 8'd77, 10, 0));
        tbl.push_back(v("ld7_en0",   1, 0, 0, 1,   7,   7, 0));
        // reset beats load
        tbl.push_back(v("rst_vs_ld", 0, 1, 0, 1,  99,   0, 0));
        tbl.push_back(v("resume1",   1, 1, 0, 0,   0,   1, 0));
        // loads at boundaries never pulse wrap
        tbl.push_back(v("ld255_up",  1, 1, 0, 1, 255, 255, 0));
        tbl.push_back(v("ld0_dn",    1, 1, 1, 1,   0,   0, 0));
        tbl.push_back(v("ld0_hold",  1, 0, 1, 0,   0,   0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // mid-count reset: clears on that edge, resumes from 0
        apply(v("mid_ld100", 1, 1, 0, 1, 100, 100, 0));
        apply(v("mid_up101", 1, 1, 0, 0,   0, 101, 0));
        apply(v("mid_rst",   0, 1, 0, 0,   0,   0, 0));
        apply(v("mid_res1",  1, 1, 0, 0,   0,   1, 0));
        apply(v("mid_res2",  1, 1, 0, 0,   0,   2, 0));

        // reset at a wrap boundary suppresses the pulse
        apply(v("bnd_ld255", 1, 0, 0, 1, 255, 255, 0));
        apply(v("bnd_rst",   0, 1, 0, 0,   0,   0, 0));

        // direction flip takes effect on the first edge that samples it
        apply(v("dir_ld20",  1, 0, 0, 1,  20,  20, 0));
        apply(v("dir_up21",  1, 1, 0, 0,   0,  21, 0));
        apply(v("dir_dn20",  1, 1, 1, 0,   0,  20, 0));
        apply(v("dir_up21b", 1, 1, 0, 0,   0,  21, 0));

        // outputs are registered: input changes between edges do not reach count
        @(negedge clk);
        load = 1'b1; data = 8'd200; enable = 1'b0; reset = 1'b0;
        #2;
        check("no_comb_path", 8'd21, 1'b0);
        @(posedge clk);
        #1;
        check("rst_after_glitch", 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
